alu: RTL

//  Execution end of the RS->ALU dispatch interface: consumes one dispatched RV32I op per cycle and

---
 rtl/alu.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu.sv
// alu: single-cycle RV32I execution unit behind the RS dispatch port.
// Each accepted op produces exactly one registered broadcast cycle on the
// alu_result bus. This bus carries the rd value, the branch/jump outcome and
// the resolved next PC.
// Optional build macro: ALU_BRANCH_STAT_EN adds the stat_br_total and
// stat_br_taken branch counters.
module alu #(
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             alu_en,
  input  logic [6:0]       alu_opcode,
  input  logic [2:0]       alu_funct3,
  input  logic             alu_funct7,
  input  logic [31:0]      alu_val1,
  input  logic [31:0]      alu_val2,
  input  logic [31:0]      alu_imm,
  input  logic [31:0]      alu_pc,
  input  logic [ROB_W-1:0] alu_rob_pos,
  output logic             alu_result,
  output logic [ROB_W-1:0] alu_result_rob_pos,
  output logic [31:0]      alu_result_val,
  output logic             alu_result_jump,
  output logic [31:0]      alu_result_pc
`ifdef ALU_BRANCH_STAT_EN
  ,
  output logic [31:0]      stat_br_total,
  output logic [31:0]      stat_br_taken
`endif
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic             r_result;
  logic [ROB_W-1:0] r_robPos;
  logic [31:0]      r_val;
  logic             r_jump;
  logic [31:0]      r_pc;

  logic [31:0] w_op2;
  logic [4:0]  w_shamt;
  logic [31:0] w_aluOut;
  logic        w_brCond;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_pcPlusImm;
  logic [31:0] w_nextVal;
  logic        w_nextJump;
  logic [31:0] w_nextPc;

  assign w_pcPlus4   = alu_pc + 32'd4;
  assign w_pcPlusImm = alu_pc + alu_imm;

  // Integer datapath shared by OP and OP-IMM; funct7 only picks SUB for register ops
  always_comb begin
    w_op2    = (alu_opcode == OPC_OP) ? alu_val2 : alu_imm;
    w_shamt  = w_op2[4:0];
    w_aluOut = 32'd0;
    case (alu_funct3)
      3'b000: w_aluOut = (alu_opcode == OPC_OP && alu_funct7) ? (alu_val1 - w_op2)
                                                              : (alu_val1 + w_op2);
      3'b001: w_aluOut = alu_val1 << w_shamt;
      3'b010: w_aluOut = {31'd0, $signed(alu_val1) < $signed(w_op2)};
      3'b011: w_aluOut = {31'd0, alu_val1 < w_op2};
      3'b100: w_aluOut = alu_val1 ^ w_op2;
      3'b101: w_aluOut = alu_funct7 ? 32'($signed(alu_val1) >>> w_shamt)
                                    : (alu_val1 >> w_shamt);
      3'b110: w_aluOut = alu_val1 | w_op2;
      3'b111: w_aluOut = alu_val1 & w_op2;
      default: w_aluOut = 32'd0;
    endcase
  end

  // Branch condition from rs1/rs2; the two undefined funct3 codes are never taken
  always_comb begin
    w_brCond = 1'b0;
    case (alu_funct3)
      3'b000: w_brCond = (alu_val1 == alu_val2);
      3'b001: w_brCond = (alu_val1 != alu_val2);
      3'b100: w_brCond = ($signed(alu_val1) < $signed(alu_val2));
      3'b101: w_brCond = ($signed(alu_val1) >= $signed(alu_val2));
      3'b110: w_brCond = (alu_val1 < alu_val2);
      3'b111: w_brCond = (alu_val1 >= alu_val2);
      default: w_brCond = 1'b0;
    endcase
  end

  // Per-opcode result selection; an unknown opcode still produces a harmless result
  always_comb begin
    w_nextVal  = 32'd0;
    w_nextJump = 1'b0;
    w_nextPc   = w_pcPlus4;
    case (alu_opcode)
      OPC_LUI:   w_nextVal = alu_imm;
      OPC_AUIPC: w_nextVal = w_pcPlusImm;
      OPC_JAL: begin
        w_nextVal  = w_pcPlus4;
        w_nextJump = 1'b1;
        w_nextPc   = w_pcPlusImm;
      end
      OPC_JALR: begin
        w_nextVal  = w_pcPlus4;
        w_nextJump = 1'b1;
        w_nextPc   = (alu_val1 + alu_imm) & ~32'd1;
      end
      OPC_BRANCH: begin
        w_nextJump = w_brCond;
        w_nextPc   = w_brCond ? w_pcPlusImm : w_pcPlus4;
      end
      OPC_OPIMM, OPC_OP: w_nextVal = w_aluOut;
      default: w_nextVal = 32'd0;
    endcase
  end

  // Result register: rollback kills the op, and rdy low freezes everything including the valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 1'b0;
      r_robPos <= '0;
      r_val    <= 32'd0;
      r_jump   <= 1'b0;
      r_pc     <= 32'd0;
    end else if (rdy) begin
      if (rollback) begin
        r_result <= 1'b0;
      end else if (alu_en) begin
        r_result <= 1'b1;
        r_robPos <= alu_rob_pos;
        r_val    <= w_nextVal;
        r_jump   <= w_nextJump;
        r_pc     <= w_nextPc;
      end else begin
        r_result <= 1'b0;
      end
    end
  end

  assign alu_result         = r_result;
  assign alu_result_rob_pos = r_robPos;
  assign alu_result_val     = r_val;
  assign alu_result_jump    = r_jump;
  assign alu_result_pc      = r_pc;

`ifdef ALU_BRANCH_STAT_EN
  logic [31:0] r_brTotal;
  logic [31:0] r_brTaken;

  // Branch statistics count every accepted branch; only reset clears them, rollback does not
  always_ff @(posedge clk) begin
    if (rst) begin
      r_brTotal <= 32'd0;
      r_brTaken <= 32'd0;
    end else if (rdy && !rollback && alu_en && alu_opcode == OPC_BRANCH) begin
      r_brTotal <= r_brTotal + 32'd1;
      if (w_brCond) begin
        r_brTaken <= r_brTaken + 32'd1;
      end
    end
  end

  assign stat_br_total = r_brTotal;
  assign stat_br_taken = r_brTaken;
`endif

endmodule
